// File: rtl/exe_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exe_pipe
// Brief    : Two-stage execute pipeline (OP, EX) with a register file, an
//            8-operation ALU with ZNCV flags, EX->OP bypassing, a global
//            stall and an external register-load port.
// Revision : 1.0 - initial release
// ============================================================================
module exe_pipe #(
    parameter int DW   = 6,
    parameter int NREG = 16,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 i_clk,
    input  logic                 i_rsn,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic [2:0]           i_oper,
    input  logic [AW-1:0]        i_reg0,
    input  logic [AW-1:0]        i_reg1,
    input  logic [AW-1:0]        i_reg2,
    input  logic signed [DW-1:0] i_data,
    input  logic                 i_imm,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic signed [DW-1:0] i_wr_data,
    output logic                 o_valid,
    output logic signed [DW-1:0] o_data,
    output logic [3:0]           o_flag
);

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_AND = 3'b010;
    localparam logic [2:0] c_OR  = 3'b011;
    localparam logic [2:0] c_XOR = 3'b100;
    localparam logic [2:0] c_SHL = 3'b101;
    localparam logic [2:0] c_SAR = 3'b110;
    localparam logic [2:0] c_MOV = 3'b111;

    // Register file
    logic [DW-1:0] rf_q [NREG];

    // OP-stage registers (the instruction currently being executed in EX)
    logic          op_vld_q;
    logic [2:0]    op_oper_q;
    logic [AW-1:0] op_dest_q;
    logic [DW-1:0] op_a_q;
    logic [DW-1:0] op_b_q;

    // Operand selection for the instruction entering the pipe
    logic [DW-1:0] op_a_d;
    logic [DW-1:0] op_b_d;

    // EX combinational result
    logic [DW-1:0] w_ex_res;
    logic          w_ex_c;
    logic          w_ex_v;
    logic [3:0]    w_ex_flag;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;

    // Operand fetch: forward the EX result when it targets a source register.
    // The RF itself is read before any same-edge external write lands.
    always_comb begin
        op_a_d = rf_q[i_reg0];
        op_b_d = rf_q[i_reg1];
        if (op_vld_q && (op_dest_q == i_reg0)) begin
            op_a_d = w_ex_res;
        end
        if (i_imm) begin
            op_b_d = i_data;
        end else if (op_vld_q && (op_dest_q == i_reg1)) begin
            op_b_d = w_ex_res;
        end
    end

    // ALU: result plus carry/borrow and signed-overflow flags
    always_comb begin
        w_sum    = {1'b0, op_a_q} + {1'b0, op_b_q};
        w_diff   = {1'b0, op_a_q} - {1'b0, op_b_q};
        w_ex_res = '0;
        w_ex_c   = 1'b0;
        w_ex_v   = 1'b0;
        case (op_oper_q)
            c_ADD: begin
                w_ex_res = w_sum[DW-1:0];
                w_ex_c   = w_sum[DW];
                w_ex_v   = (op_a_q[DW-1] == op_b_q[DW-1]) &&
                           (w_sum[DW-1] != op_a_q[DW-1]);
            end
            c_SUB: begin
                // borrow bit of the widened difference equals A < B unsigned
                w_ex_res = w_diff[DW-1:0];
                w_ex_c   = w_diff[DW];
                w_ex_v   = (op_a_q[DW-1] != op_b_q[DW-1]) &&
                           (w_diff[DW-1] != op_a_q[DW-1]);
            end
            c_AND: w_ex_res = op_a_q & op_b_q;
            c_OR:  w_ex_res = op_a_q | op_b_q;
            c_XOR: w_ex_res = op_a_q ^ op_b_q;
            c_SHL: begin
                w_ex_res = {op_a_q[DW-2:0], 1'b0};
                w_ex_c   = op_a_q[DW-1];
            end
            c_SAR: begin
                w_ex_res = {op_a_q[DW-1], op_a_q[DW-1:1]};
                w_ex_c   = op_a_q[0];
            end
            c_MOV: w_ex_res = op_b_q;
            default: w_ex_res = '0;
        endcase
        w_ex_flag = {(w_ex_res == '0), w_ex_res[DW-1], w_ex_c, w_ex_v};
    end

    // OP-stage register: captures the new instruction unless stalled
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            op_vld_q  <= 1'b0;
            op_oper_q <= '0;
            op_dest_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else if (!i_stall) begin
            op_vld_q  <= i_valid;
            op_oper_q <= i_oper;
            op_dest_q <= i_reg2;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
        end
    end

    // EX-stage output register: data/flags only move on a valid result
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_flag  <= '0;
        end else if (!i_stall) begin
            o_valid <= op_vld_q;
            if (op_vld_q) begin
                o_data <= w_ex_res;
                o_flag <= w_ex_flag;
            end
        end
    end

    // Register file writes: write-back is applied last so it wins a collision
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (!i_stall) begin
            if (i_wr_en) begin
                rf_q[i_wr_addr] <= i_wr_data;
            end
            if (op_vld_q) begin
                rf_q[op_dest_q] <= w_ex_res;
            end
        end
    end

endmodule
`default_nettype wire
